modport_mem: RTL and testbench



---
 rtl/mem_pkg.sv | 11 +
 rtl/modport_mem_array.sv | 51 +++++
 rtl/modport_mem.sv | 49 ++++
 tb/tb_modport_mem.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared sizing constants and word/address types for the 32 x 8 test memory.
package mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage : mem_pkg

// File: rtl/modport_mem_array.sv
// Resettable DEPTH x DATA_W register array with one write port and a
// combinational read tap. The array has to clear completely on reset, so it is
// built from flops rather than block RAM.
module modport_mem_array
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  addr_t raddr,
  output data_t rdata
);

  data_t            mem_q [DEPTH];
  data_t            mem_d [DEPTH];
  logic [DEPTH-1:0] word_sel;

  // One-hot write decode, one select line per word.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign word_sel[gi] = we && (waddr == addr_t'(gi));
    end
  endgenerate

  // Next-state: every word holds unless its select line is active.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = word_sel[i] ? wdata : mem_q[i];
    end
  end

  // Storage, cleared asynchronously so a reset mid-write discards that write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // The read tap shows the pre-edge contents, which gives read-first behaviour.
  assign rdata = mem_q[raddr];

endmodule : modport_mem_array

// File: rtl/modport_mem.sv
// Single-port 32 x 8 memory for the memory-test master. Reads are registered
// with one cycle of latency. A simultaneous read and write returns the old word
// and then stores the new one.
module modport_mem
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  data_t rd_word;
  data_t data_out_q;
  data_t data_out_d;

  modport_mem_array u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (write),
    .waddr (addr),
    .wdata (data_in),
    .raddr (addr),
    .rdata (rd_word)
  );

  // Capture the addressed word on a read. Otherwise the output holds.
  always_comb begin
    data_out_d = data_out_q;
    if (read) begin
      data_out_d = rd_word;
    end
  end

  // Output register. It is cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule : modport_mem

// File: tb/tb_modport_mem.sv
// Directed bench for modport_mem. Stimulus changes on the falling edge, and
// data_out is sampled 1 ns after the rising edge.
module tb_modport_mem;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  modport_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: data_out=%02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: data_out=%02h", name, act);
    end
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic cycle(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [7:0] d);
    @(negedge clk);
    read    = rd;
    write   = wr;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rd, input logic wr, input logic [4:0] a,
                     input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    // Expected values are hand-derived from the read-first memory behaviour.
    for (int i = 0; i < 26; i++) add(1'b0, 1'b1, 5'(i), 8'(8'h41 + i), 8'h00);
    for (int i = 0; i < 26; i++) add(1'b1, 1'b0, 5'(i), 8'h00, 8'(8'h41 + i));
    add(1'b1, 1'b0, 5'd26, 8'h00, 8'h00);   // never written -> 0
    add(1'b0, 1'b1, 5'd31, 8'hFF, 8'h00);
    add(1'b0, 1'b1, 5'd0,  8'h5A, 8'h00);
    add(1'b1, 1'b0, 5'd31, 8'h00, 8'hFF);
    add(1'b1, 1'b0, 5'd0,  8'h00, 8'h5A);
    add(1'b0, 1'b1, 5'd7,  8'h3C, 8'h5A);   // write leaves data_out alone
    add(1'b1, 1'b0, 5'd7,  8'h00, 8'h3C);   // read-after-write
    add(1'b0, 1'b0, 5'd7,  8'h00, 8'h3C);   // idle holds
    add(1'b0, 1'b0, 5'd3,  8'h99, 8'h3C);
    add(1'b0, 1'b1, 5'd9,  8'h11, 8'h3C);
    add(1'b1, 1'b1, 5'd9,  8'h22, 8'h11);   // read-first returns old
    add(1'b1, 1'b0, 5'd9,  8'h00, 8'h22);   // then new
    add(1'b1, 1'b0, 5'd1,  8'h00, 8'h42);

    read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    rst_n = 1'b0;
    #12;
    check("reset_initial", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      cycle(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].din);
      check($sformatf("vec%0d rd=%0d wr=%0d a=%0d", k, vecs[k].rd, vecs[k].wr,
                      vecs[k].addr), data_out, vecs[k].exp);
    end

    // Reset mid-run: data_out (0x42) clears without waiting for a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_async_clear", data_out, 8'h00);
    @(posedge clk);
    #1 check("reset_held", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 5'd0,  8'h00); check("post_reset_rd0",  data_out, 8'h00);
    cycle(1'b1, 1'b0, 5'd15, 8'h00); check("post_reset_rd15", data_out, 8'h00);
    cycle(1'b1, 1'b0, 5'd31, 8'h00); check("post_reset_rd31", data_out, 8'h00);
    cycle(1'b1, 1'b0, 5'd9,  8'h00); check("post_reset_rd9",  data_out, 8'h00);

    // Reset asserted between edges while a write to addr 4 is pending.
    cycle(1'b0, 1'b1, 5'd4, 8'h55);
    cycle(1'b1, 1'b0, 5'd4, 8'h00); check("pre_rst_rd4", data_out, 8'h55);
    @(negedge clk);
    read = 1'b0; write = 1'b1; addr = 5'd4; data_in = 8'h77;
    #2 rst_n = 1'b0;
    #1 check("rst_during_write", data_out, 8'h00);
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 5'd4, 8'h00); check("rd4_after_rst", data_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_modport_mem
